decoder2_arbiter: RTL and testbench

Round-robin arbiter/sequencer that shares the 2-to-4 `decoder2` enable decoder among four requesters. It picks one requester, drives the decoder select (`sel`) and enable (`en`), and holds the grant until the owner releases it. It also exports a registered one-hot grant that matches the decoder output. It sits between requesting agents and `decoder2`, so `decoder2` stays a pure combinational block.

---
 rtl/decoder2_arbiter.sv | 159 +++++++++++++++
 tb/tb_decoder2_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/decoder2_arbiter.sv
// Round-robin arbiter that shares one 2-to-4 decoder2 among four requesters.
// Optional forced release after HOLD_MAX grant cycles: define DEC2_ARB_TIMEOUT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no owner, decoder disabled, arbitrating every cycle
// ST_GRANT | sel frozen on the owner, decoder enabled until release
// ST_GAP   | one break-before-make cycle with en=0, arbitration runs
module decoder2_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [1:0] sel,
  output logic       en,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  if (HOLD_MAX < 1 || HOLD_MAX > 15 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_cfg
    $error("decoder2_arbiter: HOLD_MAX must be 1..15 and below 2**CNT_W");
  end

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic       en_q, en_d;
  logic [3:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;

  logic       found;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       release_own;
  logic       force_rel;

  // Search starts just past the previous owner, so it always comes last.
  always_comb begin
    found  = 1'b0;
    winner = last_q;
    cand   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign release_own = done[sel_q] | ~req[sel_q];

`ifdef DEC2_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign force_rel = (state_q == ST_GRANT) && (cnt_q == CNT_W'(HOLD_MAX - 1));

  // Count is zero on the first GRANT cycle and saturates instead of wrapping.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = force_rel & ~release_own;
    if (state_q != ST_GRANT) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    en_d    = en_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (found) begin
          state_d = ST_GRANT;
          sel_d   = winner;
          last_d  = winner;
          en_d    = 1'b1;
          gnt_d   = 4'b0001 << winner;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_own || force_rel) begin
          state_d = ST_GAP;
          en_d    = 1'b0;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'b00;
      last_q  <= 2'b11;
      en_q    <= 1'b0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign sel  = sel_q;
  assign en   = en_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_decoder2_arbiter.sv
// Self-checking bench for decoder2_arbiter: vector table plus hand-written
// corner sequences (timeout branch follows DEC2_ARB_TIMEOUT_EN).
module tb_decoder2_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] done = 4'b0000;
  logic [1:0] sel;
  logic       en;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decoder2_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .sel(sel), .en(en), .gnt(gnt), .busy(busy), .timeout(timeout)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic       en;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       busy;
    logic       tmo;
    string      name;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[26];

  task automatic check_now(input vec_t e);
    checks++;
    if ({en, sel, gnt, busy, timeout} !== {e.en, e.sel, e.gnt, e.busy, e.tmo}) begin
      errors++;
      $display("FAIL %s: got en=%b sel=%0d gnt=%b busy=%b timeout=%b, want en=%b sel=%0d gnt=%b busy=%b timeout=%b",
               e.name, en, sel, gnt, busy, timeout, e.en, e.sel, e.gnt, e.busy, e.tmo);
    end
  endtask

  // Inputs change on the falling edge; the result is checked one falling edge later.
  task automatic apply(input vec_t v);
    req  = v.req;
    done = v.done;
    exp_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    check_now(exp_q.pop_front());
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] d, input logic e,
                              input logic [1:0] s, input logic [3:0] g, input logic b,
                              input logic t, input string n);
    vec_t v;
    v.req = r; v.done = d; v.en = e; v.sel = s; v.gnt = g; v.busy = b; v.tmo = t; v.name = n;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(4'b1111, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, "first_grant_0");
    tbl[1]  = mk(4'b1111, 4'b0001, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, "rel_0_gap");
    tbl[2]  = mk(4'b1111, 4'b0000, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0, "rot_grant_1");
    tbl[3]  = mk(4'b1111, 4'b0010, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0, "rel_1_gap");
    tbl[4]  = mk(4'b1111, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, "rot_grant_2");
    tbl[5]  = mk(4'b1111, 4'b0100, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0, "rel_2_gap");
    tbl[6]  = mk(4'b1111, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b0, "rot_grant_3");
    tbl[7]  = mk(4'b1111, 4'b1000, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0, "rel_3_gap");
    tbl[8]  = mk(4'b1111, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, "rot_wrap_0");
    tbl[9]  = mk(4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, "reqdrop_0");
    tbl[10] = mk(4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, "idle_none");
    tbl[11] = mk(4'b0100, 4'b0010, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, "grant_2_only");
    tbl[12] = mk(4'b0100, 4'b0010, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, "nonowner_done_ign");
    tbl[13] = mk(4'b0000, 4'b0010, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0, "reqdrop_2");
    tbl[14] = mk(4'b0000, 4'b0010, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0, "idle_after_drop");
    tbl[15] = mk(4'b0000, 4'b0010, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0, "idle_stays");
    tbl[16] = mk(4'b0010, 4'b0000, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0, "grant_1");
    tbl[17] = mk(4'b1010, 4'b0010, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0, "simul_rel_newreq");
    tbl[18] = mk(4'b1000, 4'b1000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b0, "gap_grant_3");
    tbl[19] = mk(4'b1000, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b0, "hold_3");
    tbl[20] = mk(4'b1001, 4'b1000, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0, "rel_3");
    tbl[21] = mk(4'b1001, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, "grant_0_after_3");
    tbl[22] = mk(4'b1001, 4'b0001, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, "rel_0_rereq");
    tbl[23] = mk(4'b1001, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b0, "rereq_lowest_prio");
    tbl[24] = mk(4'b1001, 4'b1000, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0, "rel_3_again");
    tbl[25] = mk(4'b0001, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, "grant_0_hold_start");

    req   = 4'b1111;
    done  = 4'b0000;
    rst_n = 1'b0;
    @(negedge clk);
    check_now(mk(4'b1111, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, "reset_hold"));
    @(negedge clk);
    check_now(mk(4'b1111, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, "reset_hold2"));
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) apply(tbl[i]);

`ifdef DEC2_ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++)
      apply(mk(4'b0001, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, "hold_before_tmo"));
    apply(mk(4'b0001, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, "timeout_pulse"));
    apply(mk(4'b0001, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, "regrant_after_tmo"));
`else
    for (int i = 0; i < 100; i++)
      apply(mk(4'b0001, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, "long_hold"));
`endif

    apply(mk(4'b0100, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, "reqdrop_pre_rst"));
    apply(mk(4'b0100, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, "grant_2_pre_rst"));

    // Mid-grant reset must clear outputs before any clock edge.
    req = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    check_now(mk(4'b1111, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, "async_rst_clear"));
    @(negedge clk);
    check_now(mk(4'b1111, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, "rst_held"));
    rst_n = 1'b1;
    apply(mk(4'b1111, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, "restart_grant_0"));
    apply(mk(4'b1111, 4'b0001, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, "restart_rel_0"));
    apply(mk(4'b1111, 4'b0000, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0, "restart_grant_1"));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
